crossbar_routed: RTL
====================

CROSSBAR_ROUTED -- requirements
Module: crossbar_routed

Interface
REQ-001: Parameter BIT_WIDTH, default 32, payload width in bits.
REQ-002: Parameter N_INPUTS, default 4, number of input channels, >= 2.
REQ-003: Parameter N_OUTPUTS, default 4, number of output channels, >= 2.
REQ-004: Parameter BUF_DEPTH, default 2, entries per output FIFO, power of two, >= 2.
REQ-005: Derived SEL_W = $clog2(N_INPUTS), FIELD_W = SEL_W+1, CONTROL_BIT_WIDTH = N_OUTPUTS*FIELD_W; these SHALL be localparams, not overridable.
REQ-006: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007: reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-008: recv_msg  input  [BIT_WIDTH-1:0] x N_INPUTS unpacked  input payloads.
REQ-009: recv_val  input  1 x N_INPUTS  input valid.
REQ-010: recv_rdy  output  1 x N_INPUTS  input ready.
REQ-011: send_msg  output  [BIT_WIDTH-1:0] x N_OUTPUTS unpacked  output payloads.
REQ-012: send_val  output  1 x N_OUTPUTS  output valid.
REQ-013: send_rdy  input  1 x N_OUTPUTS  output ready.
REQ-014: control  input  CONTROL_BIT_WIDTH  routing table; field k = control[k*FIELD_W +: FIELD_W], MSB = enable, low SEL_W bits = source input index for output k.
REQ-015: control_val  input  1  control valid.
REQ-016: control_rdy  output  1  control ready.

Function
REQ-017: A transfer SHALL occur on any port when its val and rdy are both 1 at a rising clk edge.
REQ-018: Each output k SHALL own a BUF_DEPTH-entry FIFO; send_val[k] = FIFO k non-empty; send_msg[k] = FIFO k head, or 0 when empty.
REQ-019: Output k is mapped to input j when table field k has enable=1 and select=j; several outputs MAY map to one input (multicast).
REQ-020: A select value >= N_INPUTS with enable=1 SHALL be treated as disabled.
REQ-021: recv_rdy[j] SHALL be 1 only when state==RUN, no control transfer occurs this cycle, input j has at least one mapped output, and every output mapped to j has a non-full FIFO.
REQ-022: An input transfer on j SHALL push recv_msg[j] into every FIFO mapped to j in the same edge (all-or-nothing).
REQ-023: Unmapped inputs SHALL hold recv_rdy=0 and lose no data.
REQ-024: Minimum latency recv to send SHALL be 1 cycle; no combinational recv->send path.
REQ-025: Output transfer on k SHALL pop FIFO k; a push and pop on the same FIFO in one edge SHALL both take effect (occupancy unchanged); a push to a full FIFO SHALL never occur.
REQ-026: FIFO pointers SHALL wrap modulo BUF_DEPTH; FIFO order SHALL be preserved per output.
REQ-027: FSM states RUN and DRAIN.
REQ-028: all_empty = every output FIFO empty; control_rdy SHALL equal all_empty in both states.
REQ-029: RUN -> DRAIN when control_val==1 and all_empty==0; recv_rdy all 0 in DRAIN; outputs keep draining.
REQ-030: On a control transfer (either state) the table SHALL load control and the state SHALL be RUN next cycle; the new table applies from the next cycle.
REQ-031: DRAIN SHALL persist while all_empty==0, including if control_val drops; DRAIN with all_empty==1 and control_val==0 SHALL return to RUN under the old table.
REQ-032: Table and FSM SHALL change only via reset or control transfer/drain rules above.

Reset
REQ-033: While reset==0 at an edge: table <= 0 (all outputs disabled), all FIFOs emptied, state <= RUN.
REQ-034: After reset: send_val all 0, send_msg all 0, recv_rdy all 0, control_rdy=1.
REQ-035: Reset asserted mid-transfer or mid-DRAIN SHALL discard buffered data with no partial state retained.

Verification
REQ-036: Reset, load table out0<-in1, out1<-in0 (others disabled); send 0xA5 on in1, 0x5A on in0 -> next cycle send_msg[0]=0xA5, send_msg[1]=0x5A, both send_val=1.
REQ-037: Multicast out0,out1,out2<-in2, hold send_rdy[1]=0 -> out1 FIFO fills after 2 words, recv_rdy[2] drops to 0, no output receives a third word until out1 drains.
REQ-038: Buffers non-empty, control_val=1 -> DRAIN, recv_rdy all 0, control_rdy=0 until FIFOs empty, then table loads, RUN resumes with new routes.
REQ-039: Full FIFO with simultaneous pop and upstream valid -> no push that edge; pop count equals push count over 20 random cycles, order preserved.
REQ-040: Select value >= N_INPUTS (N_INPUTS=3) with enable=1 -> that output never asserts send_val.
REQ-041: Reset asserted during DRAIN with 2 words buffered -> next cycle send_val all 0, control_rdy=1, table disabled.

Source files
------------

// File: rtl/crossbar_routed.sv
// crossbar_routed: N_INPUTS x N_OUTPUTS routed crossbar with a small FIFO per
// output. A runtime routing table selects one source input per output
// (multicast allowed). The table is only replaced once every output FIFO has
// drained, so words already in flight always leave under the routes that
// accepted them.
module crossbar_routed #(
  parameter  int BIT_WIDTH         = 32,
  parameter  int N_INPUTS          = 4,
  parameter  int N_OUTPUTS         = 4,
  parameter  int BUF_DEPTH         = 2,
  localparam int SEL_W             = $clog2(N_INPUTS),
  localparam int FIELD_W           = SEL_W + 1,
  localparam int CONTROL_BIT_WIDTH = N_OUTPUTS * FIELD_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BIT_WIDTH-1:0]         recv_msg [N_INPUTS],
  input  logic [N_INPUTS-1:0]          recv_val,
  output logic [N_INPUTS-1:0]          recv_rdy,
  output logic [BIT_WIDTH-1:0]         send_msg [N_OUTPUTS],
  output logic [N_OUTPUTS-1:0]         send_val,
  input  logic [N_OUTPUTS-1:0]         send_rdy,
  input  logic [CONTROL_BIT_WIDTH-1:0] control,
  input  logic                         control_val,
  output logic                         control_rdy
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SEL_W:0]   N_IN_LIM  = (SEL_W + 1)'(N_INPUTS);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                         state_reg, state_next;
  logic [CONTROL_BIT_WIDTH-1:0]   table_reg, table_next;

  logic [N_OUTPUTS-1:0]           out_en;
  logic [SEL_W-1:0]               out_sel [N_OUTPUTS];
  logic [N_OUTPUTS-1:0]           fifo_empty;
  logic [N_OUTPUTS-1:0]           fifo_full;
  logic [N_OUTPUTS-1:0]           push;
  logic [N_OUTPUTS-1:0]           pop;

  logic [N_INPUTS-1:0]            in_mapped;
  logic [N_INPUTS-1:0]            in_blocked;
  logic [N_INPUTS-1:0]            recv_xfer;

  logic                           all_empty;
  logic                           ctrl_xfer;

  assign all_empty   = &fifo_empty;
  assign control_rdy = all_empty;
  assign ctrl_xfer   = control_val && all_empty;
  assign recv_xfer   = recv_val & recv_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUTPUTS; gi++) begin : g_out
      logic [FIELD_W-1:0]   field;
      logic [BIT_WIDTH-1:0] mem [BUF_DEPTH];
      logic [PTR_W-1:0]     wr_ptr_reg;
      logic [PTR_W-1:0]     rd_ptr_reg;
      logic [CNT_W-1:0]     count_reg;

      // Decode this output's routing field; out-of-range selects count as disabled.
      assign field       = table_reg[gi*FIELD_W +: FIELD_W];
      assign out_sel[gi] = field[SEL_W-1:0];
      assign out_en[gi]  = field[SEL_W] && ({1'b0, field[SEL_W-1:0]} < N_IN_LIM);

      assign fifo_empty[gi] = (count_reg == '0);
      assign fifo_full[gi]  = (count_reg == DEPTH_CNT);
      assign push[gi]       = out_en[gi] && recv_xfer[out_sel[gi]];
      assign pop[gi]        = send_val[gi] && send_rdy[gi];

      assign send_val[gi] = !fifo_empty[gi];
      assign send_msg[gi] = fifo_empty[gi] ? '0 : mem[rd_ptr_reg];

      // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
      always_ff @(posedge clk) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      // Storage write; contents need no reset because occupancy gates visibility.
      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_ptr_reg] <= recv_msg[out_sel[gi]];
      end
    end
  endgenerate

  // An input is ready only if it feeds at least one output and none of those outputs is full.
  always_comb begin
    in_mapped  = '0;
    in_blocked = '0;
    recv_rdy   = '0;
    for (int j = 0; j < N_INPUTS; j++) begin
      for (int k = 0; k < N_OUTPUTS; k++) begin
        if (out_en[k] && (out_sel[k] == SEL_W'(j))) begin
          in_mapped[j] = 1'b1;
          if (fifo_full[k]) in_blocked[j] = 1'b1;
        end
      end
      recv_rdy[j] = (state_reg == RUN) && !ctrl_xfer && in_mapped[j] && !in_blocked[j];
    end
  end

  // State and routing table registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= RUN;
      table_reg <= '0;
    end else begin
      state_reg <= state_next;
      table_reg <= table_next;
    end
  end

  // Next-state: load table when drained, otherwise hold off inputs until FIFOs empty.
  always_comb begin
    state_next = state_reg;
    table_next = table_reg;
    if (ctrl_xfer) begin
      table_next = control;
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (control_val) state_next = DRAIN;
        DRAIN:   if (all_empty && !control_val) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

endmodule
